// File: rtl/rf_ctx.sv
// -----------------------------------------------------------------------------
// rf_ctx - register-file context save/restore engine.
//
// Save mode copies r0..r(NREG-1) (PC slot last) from a spare register-file
// read port to memory at base, base+1, ...  Restore mode reads the same memory
// block and writes each word back through the register-file write port.
// The CPU keeps its register file frozen while busy=1, so the combinational
// read data stays stable across memory wait states.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin an operation (sampled only in IDLE)
//   mode       in   0 = save (RF -> memory), 1 = restore (memory -> RF)
//   base       in   memory base word address, captured at start
//   busy       out  operation in progress (through the DONE cycle)
//   done       out  one-cycle completion pulse
//   rf_ra      out  register-file read address
//   rf_rd      in   register-file read data (combinational from rf_ra)
//   rf_wen     out  register-file write enable
//   rf_wa      out  register-file write address
//   rf_din     out  register-file write data
//   mem_req    out  memory request
//   mem_we     out  memory write (1) / read (0), valid while mem_req=1
//   mem_addr   out  memory word address (base + idx, wraps)
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid in the mem_ack cycle
//   mem_ack    in   memory handshake, sampled while mem_req=1
// -----------------------------------------------------------------------------
module rf_ctx #(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     base,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] rf_ra,
    input  logic [WIDTH-1:0]     rf_rd,
    output logic                 rf_wen,
    output logic [ADDR_SIZE-1:0] rf_wa,
    output logic [WIDTH-1:0]     rf_din,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata,
    input  logic                 mem_ack
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SAVE = 3'd1,
        ST_RLD  = 3'd2,
        ST_RWR  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [ADDR_SIZE-1:0] IDX_LAST = {ADDR_SIZE{1'b1}};
    localparam logic [ADDR_SIZE-1:0] IDX_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]       base_q, base_d;
    logic [WIDTH-1:0]       data_q, data_d;

    logic busy_s, done_s, rf_wen_s, mem_req_s, mem_we_s, save_s;

    // State and datapath registers; reset aborts any transfer in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= {ADDR_SIZE{1'b0}};
            base_q  <= {WIDTH{1'b0}};
            data_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            data_q  <= data_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base;
                    idx_d   = {ADDR_SIZE{1'b0}};
                    state_d = mode ? ST_RLD : ST_SAVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE: begin
                // Hold address/data until the memory accepts the write
                if (mem_ack) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_SAVE;
                    end
                end else begin
                    state_d = ST_SAVE;
                end
            end
            ST_RLD: begin
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    state_d = ST_RWR;
                end else begin
                    state_d = ST_RLD;
                end
            end
            ST_RWR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_RLD;
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here; new work begins from IDLE
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        busy_s    = 1'b0;
        done_s    = 1'b0;
        rf_wen_s  = 1'b0;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
        save_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_SAVE: begin
                busy_s    = 1'b1;
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                save_s    = 1'b1;
            end
            ST_RLD: begin
                busy_s    = 1'b1;
                mem_req_s = 1'b1;
            end
            ST_RWR: begin
                busy_s   = 1'b1;
                rf_wen_s = 1'b1;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign busy     = busy_s;
    assign done     = done_s;
    assign rf_wen   = rf_wen_s;
    assign mem_req  = mem_req_s;
    assign mem_we   = mem_we_s;
    assign rf_ra    = idx_q;
    assign rf_wa    = idx_q;
    assign rf_din   = data_q;
    // Zero-extended index added to the base; the sum wraps modulo 2^WIDTH
    assign mem_addr = base_q + {{(WIDTH-ADDR_SIZE){1'b0}}, idx_q};
    // Read data is only forwarded while saving so the bus idles at zero
    assign mem_wdata = save_s ? rf_rd : {WIDTH{1'b0}};

endmodule

// File: tb/tb_rf_ctx.sv
module tb_rf_ctx;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [31:0] base;
    logic        busy, done;
    logic [3:0]  rf_ra, rf_wa;
    logic [31:0] rf_rd, rf_din;
    logic        rf_wen;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    rf_ctx #(.WIDTH(32), .ADDR_SIZE(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base),
        .busy(busy), .done(done), .rf_ra(rf_ra), .rf_rd(rf_rd),
        .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_din(rf_din),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Register file and memory models
    logic [31:0] rf  [0:15];
    logic [31:0] mem [0:255];
    int          ack_dly = 0;
    int          wait_cnt = 0;
    logic        preload = 1'b0;
    logic [31:0] preload_base = 32'h0;

    assign rf_rd     = rf[rf_ra];
    assign mem_rdata = mem[mem_addr[7:0]];
    assign mem_ack   = mem_req && (wait_cnt >= ack_dly);

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                logic [31:0] a;
                a = preload_base + 32'(i);
                rf[i]       <= 32'h0000_00A0 + 32'(i);
                mem[a[7:0]] <= 32'h0000_5000 + 32'(i);
            end
        end else begin
            if (rf_wen) rf[rf_wa] <= rf_din;
            if (mem_req && mem_we && mem_ack) mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        mode;
        logic [31:0] base;
        int          dly;
        int          inj;       // cycle in which a stray start (mode flipped) is driven, 0 = none
        int          exp_done;
        int          exp_busy;
        int          exp_wr;
        int          exp_wen;
    } vec_t;

    logic [31:0] wr_addr[$], wr_data[$], wen_din[$];
    int          wr_cyc[$], wen_cyc[$], wen_wa[$];

    task automatic do_preload(input logic [31:0] b);
        @(negedge clk);
        preload_base = b;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   busy_cnt, done_cnt, done_cyc, per;
        logic p_wait, p_we;
        logic [31:0] p_addr, p_wdata;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1; p_wait = 1'b0;
        p_we = 1'b0; p_addr = 32'h0; p_wdata = 32'h0;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        wen_din.delete(); wen_cyc.delete(); wen_wa.delete();
        ack_dly = v.dly;
        do_preload(v.base);
        start = 1'b1; mode = v.mode; base = v.base;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = k; end
            if (mem_req && mem_we && mem_ack) begin
                wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata); wr_cyc.push_back(k);
            end
            if (rf_wen) begin
                wen_wa.push_back(int'(rf_wa)); wen_din.push_back(rf_din); wen_cyc.push_back(k);
            end
            if (p_wait && mem_req) begin
                check({tag, " hold_addr"}, mem_addr, p_addr);
                check({tag, " hold_we"}, {31'h0, mem_we}, {31'h0, p_we});
                check({tag, " hold_wdata"}, mem_wdata, p_wdata);
            end
            p_wait = mem_req && !mem_ack;
            p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
            if (k == v.inj) begin
                start = 1'b1; mode = ~v.mode; base = 32'h0000_0000;
            end else begin
                start = 1'b0;
            end
            if (done_cnt > 0 && k >= done_cyc + 2) break;
        end
        start = 1'b0;
        check({tag, " done_count"}, 32'(done_cnt), 32'd1);
        check({tag, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(v.exp_busy));
        check({tag, " busy_after"}, {31'h0, busy}, 32'h0);
        check({tag, " n_writes"}, 32'(wr_addr.size()), 32'(v.exp_wr));
        check({tag, " n_rf_wen"}, 32'(wen_wa.size()), 32'(v.exp_wen));
        per = v.mode ? v.dly + 2 : v.dly + 1;
        for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
            check({tag, $sformatf(" wr_addr[%0d]", i)}, wr_addr[i], v.base + 32'(i));
            check({tag, $sformatf(" wr_data[%0d]", i)}, wr_data[i], 32'h0000_00A0 + 32'(i));
            check({tag, $sformatf(" wr_cyc[%0d]", i)}, 32'(wr_cyc[i]), 32'(per * (i + 1)));
        end
        for (int i = 0; i < wen_wa.size() && i < 16; i++) begin
            check({tag, $sformatf(" rf_wa[%0d]", i)}, 32'(wen_wa[i]), 32'(i));
            check({tag, $sformatf(" rf_din[%0d]", i)}, wen_din[i], 32'h0000_5000 + 32'(i));
            check({tag, $sformatf(" wen_cyc[%0d]", i)}, 32'(wen_cyc[i]), 32'(per * (i + 1)));
        end
        if (v.mode) begin
            check({tag, " rf_pc_restored"}, rf[15], 32'h0000_500F);
            check({tag, " rf0_restored"}, rf[0], 32'h0000_5000);
        end
    endtask

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0100, 0, 0, 17, 17, 16, 0};   // zero-wait save
        vecs[1] = '{1'b0, 32'h0000_0100, 3, 0, 65, 65, 16, 0};   // 3 wait cycles per write
        vecs[2] = '{1'b1, 32'h0000_0200, 0, 0, 33, 33, 0, 16};   // zero-wait restore
        vecs[3] = '{1'b0, 32'hFFFF_FFF8, 0, 0, 17, 17, 16, 0};   // address wrap
        vecs[4] = '{1'b1, 32'h0000_0300, 1, 0, 49, 49, 0, 16};   // restore with 1 wait
        vecs[5] = '{1'b0, 32'h0000_0100, 0, 6, 17, 17, 16, 0};   // stray start at idx=5
        vecs[6] = '{1'b0, 32'h0000_0100, 0, 17, 17, 17, 16, 0};  // start in DONE cycle

        reset = 1'b0; start = 1'b0; mode = 1'b0; base = 32'h0;
        repeat (3) @(negedge clk);
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst done", {31'h0, done}, 32'h0);
        check("rst ctrl", {28'h0, mem_req, mem_we, rf_wen, 1'b0}, 32'h0);
        check("rst rf_ra", {28'h0, rf_ra}, 32'h0);
        check("rst rf_wa", {28'h0, rf_wa}, 32'h0);
        check("rst rf_din", rf_din, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        reset = 1'b1;

        for (int n = 0; n < 7; n++) run_vec(vecs[n], $sformatf("v%0d", n));

        // Explicit wrap point: ninth write lands at address zero
        run_vec(vecs[3], "wrap");
        if (wr_addr.size() > 8) begin
            check("wrap addr7", wr_addr[7], 32'hFFFF_FFFF);
            check("wrap addr8", wr_addr[8], 32'h0000_0000);
        end else begin
            check("wrap n_writes", 32'(wr_addr.size()), 32'd16);
        end

        // Reset during restore while idx=7 is being written back
        ack_dly = 0;
        do_preload(32'h0000_0200);
        start = 1'b1; mode = 1'b1; base = 32'h0000_0200;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 16; k++) @(negedge clk);
        check("abort pre rf_wen", {31'h0, rf_wen}, 32'h1);
        check("abort pre rf_wa", {28'h0, rf_wa}, 32'h7);
        reset = 1'b0;
        #1;
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort rf_wen", {31'h0, rf_wen}, 32'h0);
        check("abort mem_req", {31'h0, mem_req}, 32'h0);
        check("abort mem_addr", mem_addr, 32'h0);
        begin
            int dn;
            dn = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (done) dn++;
            end
            check("abort no_done", 32'(dn), 32'h0);
        end
        check("abort rf6 kept", rf[6], 32'h0000_5006);
        check("abort rf7 untouched", rf[7], 32'h0000_00A7);
        reset = 1'b1;
        @(negedge clk);
        check("abort idle busy", {31'h0, busy}, 32'h0);
        run_vec(vecs[2], "restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_ctx.md
Name: rf_ctx

Overview:
Context save/restore engine for the CPU register file.
- Save mode: reads r0..r(2^ADDR_SIZE-1), including the PC slot, through a spare register-file read port and writes each value to memory.
- Restore mode: reads the same memory block and writes every register back through the register-file write port.
- Sits between the register file and the memory bus. The CPU holds its counter enable low while busy=1.

Parameters:
WIDTH, 32, data and memory address width
ADDR_SIZE, 4, register index width; NREG = 2^ADDR_SIZE registers transferred

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin operation; sampled only in IDLE
mode  in  1  0 = save (RF to memory), 1 = restore (memory to RF)
base  in  WIDTH  memory base address; captured at start
busy  out  1  high from the cycle after start until the end of DONE
done  out  1  one-cycle completion pulse
rf_ra  out  ADDR_SIZE  register-file read address
rf_rd  in  WIDTH  register-file read data, combinational from rf_ra
rf_wen  out  1  register-file write enable
rf_wa  out  ADDR_SIZE  register-file write address
rf_din  out  WIDTH  register-file write data
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  WIDTH  memory word address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data; valid in the mem_ack cycle
mem_ack  in  1  request accepted or complete; sampled at clk edge while mem_req=1

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; idx=0; base_q=0; data_q=0.
  - busy, done, mem_req, mem_we and rf_wen are all 0.
  - rf_ra, rf_wa, mem_addr, mem_wdata and rf_din are all 0.
  - Reset asserted mid-operation aborts immediately. No done pulse is produced, and a partial transfer is left as-is.
- Internal registers: idx (ADDR_SIZE bits), base_q (WIDTH), data_q (WIDTH), state.
- Address arithmetic: mem_addr = base_q + zero-extended idx, truncated to WIDTH bits, so it wraps modulo 2^WIDTH.
- rf_ra = idx, rf_wa = idx, rf_din = data_q, mem_wdata = rf_rd.
- States and transitions:
  - IDLE: if start=1 at a clk edge, set base_q <= base and idx <= 0, then go to SAVE (mode=0) or RLD (mode=1). Otherwise start is ignored.
  - SAVE:
    - Outputs: mem_req=1, mem_we=1, busy=1.
    - On mem_ack=1: if idx = NREG-1, go to DONE; else idx <= idx+1 and stay in SAVE.
    - With a zero-wait memory (mem_ack high in the first req cycle), each register takes 1 cycle.
  - RLD:
    - Outputs: mem_req=1, mem_we=0, busy=1.
    - On mem_ack=1: data_q <= mem_rdata, go to RWR.
  - RWR:
    - Outputs: rf_wen=1 for exactly one cycle, busy=1, mem_req=0.
    - Next: if idx = NREG-1, go to DONE; else idx <= idx+1 and go to RLD.
    - Each restored register takes at least 2 cycles.
  - DONE: done=1 and busy=1 for one cycle, then IDLE.
- Handshake rule: while mem_req=1 and mem_ack=0, mem_addr, mem_we and mem_wdata must stay stable. mem_wdata is stable because the register file is frozen while busy=1.
- Transfer order is ascending. The PC slot (NREG-1) is restored last.
- start while busy=1: ignored, with no effect on the current operation.
- start asserted in the DONE cycle: ignored. A new operation can only begin from IDLE.
- Latency, zero-wait memory with start at edge 0:
  - Save: busy high at cycles 1..17; done=1 at cycle 17.
  - Restore: done=1 at cycle 33.
- mem_ack while mem_req=0: ignored.

Test Plan:
- Save, base=0x100, regs ri=0xA0+i, mem_ack tied 1 -> 16 writes with mem_addr 0x100..0x10F and mem_wdata 0xA0..0xAF; done exactly once, at cycle 17.
- Save with 3-cycle ack delay per access -> mem_addr and mem_wdata stable across each 3 wait cycles; total busy = 16*4+1 cycles.
- Restore, base=0x200, memory[0x200+i]=0x5000+i -> 16 single-cycle rf_wen pulses with rf_wa=i and rf_din=0x5000+i; last pulse at rf_wa=15; done after it.
- Wrap: base=0xFFFFFFF8, save -> mem_addr runs 0xFFFFFFF8..0xFFFFFFFF, then 0x0..0x7.
- start pulsed again at idx=5 with mode flipped -> ignored; original save completes with 16 writes and a single done.
- reset driven low during restore at idx=7 -> busy, rf_wen and mem_req go to 0 immediately; no done; a new start after release restarts at idx=0.
